// File: rtl/seg7_scan_if.sv
// Seven-segment scan controller bus: shadow-register load side plus the
// registered, active-low display drive side.
// Ports: data_i/dp_i/en_i/load_i (frame content), lz_blank_i/bright_i (live
// controls), CAT/DP/AN (segment, decimal point, anode drive), frame_o (pulse).
interface seg7_scan_if #(
  parameter int NUM_DIGITS   = 8,
  parameter int BRIGHT_WIDTH = 4
);
  logic [4*NUM_DIGITS-1:0] data_i;
  logic                    load_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   en_i;
  logic                    lz_blank_i;
  logic [BRIGHT_WIDTH-1:0] bright_i;
  logic [6:0]              CAT;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    frame_o;

  // Driver of frame content and controls (the system side).
  modport master (
    output data_i, load_i, dp_i, en_i, lz_blank_i, bright_i,
    input  CAT, DP, AN, frame_o
  );

  // The scan controller itself.
  modport slave (
    input  data_i, load_i, dp_i, en_i, lz_blank_i, bright_i,
    output CAT, DP, AN, frame_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed hex seven-segment scan controller with tear-free frame update,
// leading-zero blanking and PWM brightness. All outputs registered, 1 clock
// after the scan state; no backpressure (load_i is always accepted).
// Ports: clk, rst_i (async active-high), bus (seg7_scan_if.slave).
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CLOCKS = 200_000,
  parameter int BRIGHT_WIDTH   = 4
) (
  input logic        clk,
  input logic        rst_i,
  seg7_scan_if.slave bus
);
  localparam int CNT_W = $clog2(REFRESH_CLOCKS);
  localparam int DIG_W = $clog2(NUM_DIGITS);

  logic [CNT_W-1:0]        cnt;
  logic [DIG_W-1:0]        dig;
  logic [BRIGHT_WIDTH-1:0] pwm;

  // Shadow registers take load_i; display registers only change at frame wrap.
  logic [4*NUM_DIGITS-1:0] sh_data, disp_data;
  logic [NUM_DIGITS-1:0]   sh_dp, disp_dp;
  logic [NUM_DIGITS-1:0]   sh_en, disp_en;

  logic                    slot_end;
  logic                    frame_wrap;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   zero_from;
  logic                    all_zero;
  logic                    lz_hit;
  logic                    lit;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h01;
      4'h1: glyph = 7'h4F;
      4'h2: glyph = 7'h12;
      4'h3: glyph = 7'h06;
      4'h4: glyph = 7'h4C;
      4'h5: glyph = 7'h24;
      4'h6: glyph = 7'h20;
      4'h7: glyph = 7'h0F;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h04;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h60;
      4'hC: glyph = 7'h31;
      4'hD: glyph = 7'h42;
      4'hE: glyph = 7'h30;
      default: glyph = 7'h38;
    endcase
  endfunction

  assign slot_end   = (cnt == CNT_W'(REFRESH_CLOCKS - 1));
  assign frame_wrap = slot_end && (dig == DIG_W'(NUM_DIGITS - 1));
  assign nib        = disp_data[{dig, 2'b00} +: 4];

  // zero_from[k] = nibbles k..NUM_DIGITS-1 are all zero (suffix AND from the top).
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero && (disp_data[4*k +: 4] == 4'h0);
      zero_from[k] = all_zero;
    end
  end

  // Digit 0 is never blanked so an all-zero value still shows "0".
  assign lz_hit = bus.lz_blank_i && (dig != '0) && zero_from[dig];
  assign lit    = disp_en[dig] && (pwm <= bus.bright_i) && !lz_hit;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      dig         <= '0;
      pwm         <= '0;
      sh_data     <= '0;
      sh_dp       <= '0;
      sh_en       <= '0;
      disp_data   <= '0;
      disp_dp     <= '0;
      disp_en     <= '0;
      bus.AN      <= '1;
      bus.CAT     <= 7'h7F;
      bus.DP      <= 1'b1;
      bus.frame_o <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) begin
        dig <= frame_wrap ? '0 : dig + DIG_W'(1);
      end
      pwm <= pwm + BRIGHT_WIDTH'(1);

      if (bus.load_i) begin
        sh_data <= bus.data_i;
        sh_dp   <= bus.dp_i;
        sh_en   <= bus.en_i;
      end

      // A load landing on the wrap cycle bypasses the shadow so it is not
      // delayed by a whole frame.
      if (frame_wrap) begin
        disp_data <= bus.load_i ? bus.data_i : sh_data;
        disp_dp   <= bus.load_i ? bus.dp_i   : sh_dp;
        disp_en   <= bus.load_i ? bus.en_i   : sh_en;
      end

      bus.frame_o <= frame_wrap;

      if (lit) begin
        bus.AN  <= ~(NUM_DIGITS'(1) << dig);
        bus.CAT <= glyph(nib);
        bus.DP  <= ~disp_dp[dig];
      end else begin
        bus.AN  <= '1;
        bus.CAT <= 7'h7F;
        bus.DP  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with 4 digits, 4 clocks per slot, 2-bit brightness.
// Table vectors and hand sequences plus a per-cycle reference model check.
module tb_seg7_scan_ctrl;
  localparam int N  = 4;
  localparam int RC = 4;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(N), .BRIGHT_WIDTH(BW)) bus ();

  seg7_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_CLOCKS(RC), .BRIGHT_WIDTH(BW)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] GLYPH [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
  int          m_t = 0;
  logic [15:0] m_sh_data = '0, m_data = '0;
  logic [3:0]  m_sh_en = '0, m_en = '0, m_sh_dp = '0, m_dp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_cat = 7'h7F;
  logic        e_dp = 1'b1, e_fr = 1'b0;
  int          md, mp;
  logic        mblank;

  // Scan position and PWM phase follow purely from clocks elapsed since reset.
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_t = 0; m_sh_data = '0; m_data = '0; m_sh_en = '0; m_en = '0;
      m_sh_dp = '0; m_dp = '0;
      e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      md = (m_t / RC) % N;
      mp = m_t % (1 << BW);
      mblank = bus.lz_blank_i && (md > 0) && ((m_data >> (4 * md)) == 16'h0);
      if (m_en[md] && (mp <= int'(bus.bright_i)) && !mblank) begin
        e_an  = ~(4'b0001 << md);
        e_cat = GLYPH[m_data[4*md +: 4]];
        e_dp  = ~m_dp[md];
      end else begin
        e_an = 4'hF; e_cat = 7'h7F; e_dp = 1'b1;
      end
      e_fr = ((m_t % (RC * N)) == RC * N - 1);
      if (e_fr) begin
        m_data = bus.load_i ? bus.data_i : m_sh_data;
        m_en   = bus.load_i ? bus.en_i   : m_sh_en;
        m_dp   = bus.load_i ? bus.dp_i   : m_sh_dp;
      end
      if (bus.load_i) begin
        m_sh_data = bus.data_i; m_sh_en = bus.en_i; m_sh_dp = bus.dp_i;
      end
      m_t++;
    end
  end

  logic chk_on = 1'b0;
  int   model_prints = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({bus.AN, bus.CAT, bus.DP, bus.frame_o} !== {e_an, e_cat, e_dp, e_fr}) begin
        errors++;
        if (model_prints < 20)
          $display("FAIL model t=%0t: got AN=%b CAT=%h DP=%b FR=%b want AN=%b CAT=%h DP=%b FR=%b",
                   $time, bus.AN, bus.CAT, bus.DP, bus.frame_o, e_an, e_cat, e_dp, e_fr);
        model_prints++;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the caller on the negedge where frame_o is first seen high.
  task automatic wait_frame(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.frame_o === 1'b1) seen = 1'b1;
    end
    chk({name, " frame timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp);
    @(negedge clk);
    bus.data_i = d; bus.en_i = en; bus.dp_i = dp; bus.load_i = 1'b1;
    @(negedge clk);
    bus.load_i = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic [3:0]  en;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  lit;   // digits expected lit
    logic [27:0] cat;   // {cat3,cat2,cat1,cat0}
    logic [3:0]  dpo;   // expected DP pin per digit
  } vec_t;

  vec_t tbl [8];

  initial begin
    int cnt_low, n;
    logic [3:0] want_an;

    tbl[0] = '{16'h12AF, 4'hF, 4'h0, 1'b0, 4'b1111, {7'h4F, 7'h12, 7'h08, 7'h38}, 4'b1111};
    tbl[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h24, 7'h01}, 4'b1111};
    tbl[2] = '{16'h0050, 4'hF, 4'h0, 1'b0, 4'b1111, {7'h01, 7'h01, 7'h24, 7'h01}, 4'b1111};
    tbl[3] = '{16'h3456, 4'hA, 4'h2, 1'b0, 4'b1010, {7'h06, 7'h7F, 7'h24, 7'h7F}, 4'b1101};
    tbl[4] = '{16'h0000, 4'hF, 4'hF, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h01}, 4'b1110};
    tbl[5] = '{16'h9CDE, 4'hF, 4'h5, 1'b1, 4'b1111, {7'h04, 7'h31, 7'h42, 7'h30}, 4'b1010};
    tbl[6] = '{16'h7B03, 4'hF, 4'h0, 1'b1, 4'b1111, {7'h0F, 7'h60, 7'h01, 7'h06}, 4'b1111};
    tbl[7] = '{16'h0408, 4'hF, 4'h0, 1'b1, 4'b0111, {7'h7F, 7'h4C, 7'h01, 7'h00}, 4'b1111};

    bus.data_i = '0; bus.load_i = 1'b0; bus.dp_i = '0; bus.en_i = '0;
    bus.lz_blank_i = 1'b0; bus.bright_i = 2'd3;

    // Reset state
    step(3);
    chk("reset AN", 32'(bus.AN), 32'hF);
    chk("reset CAT", 32'(bus.CAT), 32'h7F);
    chk("reset DP", 32'(bus.DP), 32'h1);
    chk("reset frame", 32'(bus.frame_o), 32'h0);
    chk_on = 1'b1;
    rst_i = 1'b0;

    // Table vectors: each frame after the load shows the record's digits.
    for (int r = 0; r < 8; r++) begin
      bus.lz_blank_i = tbl[r].lz;
      do_load(tbl[r].data, tbl[r].en, tbl[r].dp);
      wait_frame($sformatf("vec%0d", r));
      for (int k = 0; k < 16; k++) begin
        int d;
        d = k / 4;
        @(negedge clk);
        want_an = tbl[r].lit[d] ? ~(4'b0001 << d) : 4'hF;
        chk($sformatf("vec%0d AN d%0d", r, d), 32'(bus.AN), 32'(want_an));
        chk($sformatf("vec%0d CAT d%0d", r, d), 32'(bus.CAT),
            tbl[r].lit[d] ? 32'(tbl[r].cat[7*d +: 7]) : 32'h7F);
        chk($sformatf("vec%0d DP d%0d", r, d), 32'(bus.DP), 32'(tbl[r].dpo[d]));
      end
    end

    // Mid-frame load is deferred; a load on the wrap cycle shows at once.
    bus.lz_blank_i = 1'b0;
    do_load(16'h12AF, 4'hF, 4'h0);
    wait_frame("tear a");                                  // n0
    step(6);
    bus.data_i = 16'h5555; bus.load_i = 1'b1;
    step(1);
    bus.load_i = 1'b0;
    step(6);                                               // n0+13
    chk("tear old digit3", 32'(bus.CAT), 32'h4F);
    step(2);                                               // n0+15
    bus.data_i = 16'h0007; bus.en_i = 4'hF; bus.load_i = 1'b1;
    step(1);                                               // n0+16
    bus.load_i = 1'b0;
    chk("wrap frame_o", 32'(bus.frame_o), 32'h1);
    chk("wrap old digit3", 32'(bus.CAT), 32'h4F);
    step(1);
    chk("wrap new digit0", 32'(bus.CAT), 32'h0F);
    step(4);
    chk("wrap new digit1", 32'(bus.CAT), 32'h01);
    wait_frame("tear b");
    step(1);
    chk("shadow kept wrap load", 32'(bus.CAT), 32'h0F);

    // Brightness: code 0 lights one clock in four, max code lights every clock.
    bus.bright_i = 2'd0;
    do_load(16'h12AF, 4'hF, 4'h0);
    wait_frame("pwm");
    for (int s = 0; s < 4; s++) begin
      cnt_low = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.AN != 4'hF) cnt_low++;
      end
      chk($sformatf("pwm0 slot%0d", s), 32'(cnt_low), 32'd1);
    end
    bus.bright_i = 2'd3;
    for (int s = 0; s < 4; s++) begin
      cnt_low = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (bus.AN == ~(4'b0001 << s)) cnt_low++;
      end
      chk($sformatf("pwm3 slot%0d", s), 32'(cnt_low), 32'd4);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      logic [15:0] d;
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      bus.data_i     = d;
      bus.en_i       = 4'($urandom);
      bus.dp_i       = 4'($urandom);
      bus.lz_blank_i = 1'($urandom);
      bus.bright_i   = 2'($urandom);
      bus.load_i     = ($urandom_range(0, 5) == 0);
    end
    @(negedge clk);
    bus.load_i = 1'b0; bus.bright_i = 2'd3;
    do_load(16'h1234, 4'hF, 4'h0);
    wait_frame("pre reset");
    step(6);

    // Asynchronous reset between edges, then restart timing.
    @(posedge clk);
    #3 rst_i = 1'b1;
    #1;
    chk("async rst AN", 32'(bus.AN), 32'hF);
    chk("async rst CAT", 32'(bus.CAT), 32'h7F);
    chk("async rst DP", 32'(bus.DP), 32'h1);
    chk("async rst frame", 32'(bus.frame_o), 32'h0);
    step(2);
    rst_i = 1'b0;
    n = 0;
    cnt_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.AN != 4'hF) cnt_low++;
      if (bus.frame_o === 1'b1) break;
    end
    chk("frame after reset", 32'(n), 32'd16);
    chk("blank after reset", 32'(cnt_low), 32'd0);
    step(20);
    chk("blank 2nd frame", 32'(bus.AN), 32'hF);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, the number of multiplexed digits (legal range 2..16).
REQ-002 The block SHALL have parameter REFRESH_CLOCKS, default 200_000, the clocks per digit slot (legal ≥ 2).
REQ-003 The block SHALL have parameter BRIGHT_WIDTH, default 4, the width of the brightness code (legal 1..8).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port data_i, input, 4*NUM_DIGITS bits: hex nibbles, with nibble k = data_i[4k+3:4k] for digit k.
REQ-007 The block SHALL have port load_i, input, 1 bit: when high, capture data_i, dp_i and en_i into the shadow registers.
REQ-008 The block SHALL have port dp_i, input, NUM_DIGITS bits: per-digit decimal point request, 1 = lit.
REQ-009 The block SHALL have port en_i, input, NUM_DIGITS bits: per-digit enable, 0 = digit blank.
REQ-010 The block SHALL have port lz_blank_i, input, 1 bit: leading-zero blanking mode, sampled live.
REQ-011 The block SHALL have port bright_i, input, BRIGHT_WIDTH bits: brightness code, sampled live.
REQ-012 The block SHALL have port CAT, output, 7 bits: segments {a,b,c,d,e,f,g} = CAT[6:0], active-low, registered.
REQ-013 The block SHALL have port DP, output, 1 bit: decimal point, active-low, registered.
REQ-014 The block SHALL have port AN, output, NUM_DIGITS bits: digit anodes, active-low, one-cold or all-ones, registered.
REQ-015 The block SHALL have port frame_o, output, 1 bit: one-cycle pulse on each wrap to digit 0, registered.

Function
REQ-016 Slot counter cnt SHALL count 0..REFRESH_CLOCKS-1 and wrap to 0, with no extra terminal cycle.
REQ-017 When cnt = REFRESH_CLOCKS-1, digit index dig SHALL advance by 1, wrapping from NUM_DIGITS-1 to 0.
REQ-018 On the cycle dig wraps to 0, frame_o SHALL be 1; otherwise frame_o SHALL be 0.
REQ-019 load_i SHALL update the shadow registers only; the display registers SHALL copy the shadow registers on the dig-wrap cycle (tear-free).
REQ-020 If load_i coincides with the dig-wrap cycle, the display registers SHALL take data_i/dp_i/en_i directly, and the shadow registers SHALL also take them.
REQ-021 A free-running BRIGHT_WIDTH-bit PWM counter pwm SHALL increment every clock and wrap.
REQ-022 The digit SHALL be lit iff en(dig)=1, pwm ≤ bright_i, and the digit is not leading-zero blanked.
REQ-023 When lz_blank_i=1, digit k≥1 SHALL be blanked iff nibbles k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be lz-blanked.
REQ-024 When lit, AN SHALL be all-ones except bit dig = 0, and CAT SHALL be the glyph of nibble dig.
REQ-025 When lit, DP SHALL be ~dp(dig); dp SHALL be ignored for lz-blanked digits.
REQ-026 When not lit, AN SHALL be all-ones, CAT SHALL be 7'h7F, and DP SHALL be 1.
REQ-027 Glyphs (hex) SHALL be: 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F, 8=00, 9=04, A=08, b=60, C=31, d=42, E=30, F=38.
REQ-028 Outputs SHALL reflect the state (cnt, dig, pwm, display registers) with exactly 1 clock latency.
REQ-029 bright_i at its maximum value SHALL give 100% duty, and bright_i=0 SHALL give 1/2^BRIGHT_WIDTH duty.

Reset
REQ-030 While rst_i=1, regardless of clk: cnt, dig, pwm, shadow and display registers SHALL be 0; AN SHALL be all-ones, CAT SHALL be 7'h7F, DP SHALL be 1, frame_o SHALL be 0.
REQ-031 Reset mid-slot SHALL take effect immediately, and after release scanning SHALL restart at digit 0 with cnt=0.
REQ-032 The display after reset SHALL be "0" on digit 0 only if en was loaded; with reset-state en=0, all digits SHALL be blank until the first frame after load_i.

Verification (NUM_DIGITS=4, REFRESH_CLOCKS=4, BRIGHT_WIDTH=2, bright_i=3 unless stated)
REQ-033 Bench SHALL check: load data_i=16'h12AF, en_i=4'hF, dp_i=0 -> after next frame_o, AN cycles 1110,1101,1011,0111, 4 clocks each, with CAT 38,08,12,4F.
REQ-034 Bench SHALL check: load data_i=16'h0050, lz_blank_i=1 -> digits 0,1 lit (01,24), digits 2,3 AN all-ones; then lz_blank_i=0 -> digit 3 shows 01.
REQ-035 Bench SHALL check: load_i with a new value mid-frame -> display unchanged until the dig-wrap; load_i on the wrap cycle -> new value shown on digit 0 that frame.
REQ-036 Bench SHALL check: bright_i=0 -> the selected anode is low exactly 1 of every 4 clocks; bright_i=3 -> low continuously within its slot.
REQ-037 Bench SHALL check: assert rst_i asynchronously mid-slot between clock edges -> AN=1111, CAT=7F, DP=1 before the next edge; after release, first frame_o occurs 16 clocks later.
REQ-038 Bench SHALL check: en_i=4'b1010, dp_i=4'b0010 -> digits 0 and 2 never lit; DP=0 only during digit-1 lit cycles.
